// File: rtl/deparser_rule_conf_arbiter.sv
// Round-robin arbiter sharing one rule-config path between host (req 0) and CPU (req 1)
// across LAYER_NUM deparser layers: decode layer, strobe once, collect read data with timeout.
module deparser_rule_conf_arbiter #(
    parameter int LAYER_NUM     = 4,
    parameter int LAYER_SEL_LSB = 24,
    parameter int TIMEOUT       = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_req_valid,
    input  logic [1:0]                i_req_wr,
    input  logic [1:0][31:0]          i_req_addr,
    input  logic [1:0][31:0]          i_req_wdata,
    output logic [1:0]                o_req_ready,
    output logic [1:0]                o_resp_valid,
    output logic [31:0]               o_resp_rdata,
    output logic                      o_resp_err,
    output logic [LAYER_NUM-1:0]      o_rule_wren,
    output logic [LAYER_NUM-1:0]      o_rule_rden,
    output logic [31:0]               o_rule_addr,
    output logic [31:0]               o_rule_wdata,
    input  logic [LAYER_NUM-1:0]      i_rule_rdata_valid,
    input  logic [LAYER_NUM-1:0][31:0] i_rule_rdata,
    output logic                      o_busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t              state, state_nxt;
    logic                rr, owner, wr, err;
    logic [7:0]          sel;
    logic [CW-1:0]       cnt;
    logic                grant, accept, req_bad, timeout;
    logic [7:0]          req_sel;
    logic [LAYER_NUM-1:0] hit;
    logic                hit_vld;
    logic [31:0]         hit_data;

    // rr pointer only matters on a tie; otherwise whoever is valid wins
    assign grant   = (&i_req_valid) ? rr : i_req_valid[1];
    assign accept  = (state == IDLE) && (|i_req_valid);
    assign req_sel = i_req_addr[grant][LAYER_SEL_LSB +: 8];
    assign req_bad = {1'b0, req_sel} >= 9'(LAYER_NUM);
    assign timeout = (cnt == CW'(TIMEOUT - 1));

    for (genvar g = 0; g < LAYER_NUM; g++) begin : g_hit
        assign hit[g] = (sel == 8'(g));
    end

    assign hit_vld = |(i_rule_rdata_valid & hit);

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < LAYER_NUM; i++)
            hit_data = hit_data | (i_rule_rdata[i] & {32{hit[i]}});
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = req_bad ? RESP : ISSUE;
            ISSUE:   state_nxt = (wr || hit_vld) ? RESP : WAIT_RD;
            WAIT_RD: if (hit_vld || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_req_ready  = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign o_rule_wren  = (state == ISSUE &&  wr) ? hit : '0;
    assign o_rule_rden  = (state == ISSUE && !wr) ? hit : '0;
    assign o_resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign o_resp_err   = (state == RESP) && err;
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            rr           <= 1'b0;
            owner        <= 1'b0;
            wr           <= 1'b0;
            err          <= 1'b0;
            sel          <= '0;
            cnt          <= '0;
            o_rule_addr  <= '0;
            o_rule_wdata <= '0;
            o_resp_rdata <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (accept) begin
                    owner        <= grant;
                    rr           <= ~grant;
                    wr           <= i_req_wr[grant];
                    sel          <= req_sel;
                    o_rule_addr  <= i_req_addr[grant];
                    o_rule_wdata <= i_req_wdata[grant];
                    err          <= req_bad;
                    if (req_bad) o_resp_rdata <= '0;
                end
                ISSUE: begin
                    cnt <= '0;
                    if (!wr && hit_vld) o_resp_rdata <= hit_data;
                end
                WAIT_RD: begin
                    cnt <= cnt + 1'b1;
                    // data arriving on the timeout cycle still counts as success
                    if (hit_vld) begin
                        o_resp_rdata <= hit_data;
                    end else if (timeout) begin
                        err          <= 1'b1;
                        o_resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deparser_rule_conf_arbiter.sv
// Directed bench: scoreboard of expected responses, pushed on accept and popped on o_resp_valid.
module tb_deparser_rule_conf_arbiter;

    localparam int LN = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [1:0]        i_req_valid, i_req_wr;
    logic [1:0][31:0]  i_req_addr, i_req_wdata;
    logic [1:0]        o_req_ready, o_resp_valid;
    logic [31:0]       o_resp_rdata;
    logic              o_resp_err;
    logic [LN-1:0]     o_rule_wren, o_rule_rden;
    logic [31:0]       o_rule_addr, o_rule_wdata;
    logic [LN-1:0]     i_rule_rdata_valid;
    logic [LN-1:0][31:0] i_rule_rdata;
    logic              o_busy;

    deparser_rule_conf_arbiter #(.LAYER_NUM(LN), .LAYER_SEL_LSB(24), .TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden),
        .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata),
        .i_rule_rdata_valid(i_rule_rdata_valid), .i_rule_rdata(i_rule_rdata),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic own;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic push(input logic o, input logic [31:0] d, input logic e, input logic c);
        exp_t x;
        x.owner = o; x.rdata = d; x.err = e; x.chk_data = c;
        sb.push_back(x);
    endtask

    task automatic check_resp(input string tag);
        exp_t x;
        chk({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_valid"}, o_resp_valid, x.owner ? 2'b10 : 2'b01);
            chk({tag, "_err"}, o_resp_err, x.err);
            if (x.chk_data) chk({tag, "_rdata"}, o_resp_rdata, x.rdata);
        end
    endtask

    // structural invariants every cycle outside reset
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("strobe_overlap", o_rule_wren & o_rule_rden, 0);
            chk("strobe_onehot", 32'($onehot0(o_rule_wren | o_rule_rden)), 1);
            chk("ready_onehot", 32'($onehot0(o_req_ready)), 1);
        end
    end

    initial begin
        i_rst = 1'b0;
        i_req_valid = '0; i_req_wr = '0; i_req_addr = '0; i_req_wdata = '0;
        i_rule_rdata_valid = '0; i_rule_rdata = '0;
        #1 i_rst = 1'b1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_strobes", {o_rule_wren, o_rule_rden}, 0);
        chk("rst_addr", o_rule_addr, 0);
        chk("rst_rdata", o_resp_rdata, 0);
        tick; tick;
        i_rst = 1'b0;

        // both requesters reading: alternate starting with req0
        i_req_valid = 2'b11; i_req_wr = 2'b00;
        i_req_addr[0] = 32'h0000_0004; i_req_addr[1] = 32'h0100_0008;
        for (int k = 0; k < 4; k++) begin
            own = k[0];
            #1 chk("rr_ready", o_req_ready, own ? 2'b10 : 2'b01);
            push(own, 32'hD000_0000 + k, 1'b0, 1'b1);
            tick;
            i_rule_rdata[own] = 32'hD000_0000 + k;
            i_rule_rdata_valid = own ? 4'b0010 : 4'b0001;
            #1 chk("rr_rden", o_rule_rden, own ? 4'b0010 : 4'b0001);
            chk("rr_ready_busy", o_req_ready, 0);
            chk("rr_addr", o_rule_addr, own ? 32'h0100_0008 : 32'h0000_0004);
            tick;
            i_rule_rdata_valid = '0;
            #1 check_resp("rr_resp");
            tick;
        end
        i_req_valid = 2'b00;

        // write from req0 to layer 1
        i_req_valid = 2'b01; i_req_wr = 2'b01;
        i_req_addr[0] = 32'h0100_0010; i_req_wdata[0] = 32'hA5A5_0001;
        #1 chk("w_ready", o_req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        i_req_valid = 2'b00;
        #1 chk("w_wren", o_rule_wren, 4'b0010);
        chk("w_rden", o_rule_rden, 0);
        chk("w_addr", o_rule_addr, 32'h0100_0010);
        chk("w_wdata", o_rule_wdata, 32'hA5A5_0001);
        tick;
        #1 check_resp("w_resp");
        chk("w_wren_off", o_rule_wren, 0);
        chk("w_addr_hold", o_rule_addr, 32'h0100_0010);
        tick;
        #1 chk("w_idle", o_busy, 0);
        chk("w_resp_off", o_resp_valid, 0);

        // read layer 2 with data in the ISSUE cycle
        i_req_valid = 2'b10; i_req_wr = 2'b00; i_req_addr[1] = 32'h0200_0000;
        #1 chk("fast_ready", o_req_ready, 2'b10);
        push(1'b1, 32'h1234_5678, 1'b0, 1'b1);
        tick;
        i_req_valid = 2'b00;
        i_rule_rdata[2] = 32'h1234_5678; i_rule_rdata_valid = 4'b0100;
        #1 chk("fast_rden", o_rule_rden, 4'b0100);
        tick;
        i_rule_rdata_valid = '0;
        #1 check_resp("fast_resp");
        tick;

        // read layer 3, no data: timeout after 15 WAIT_RD cycles; stray layer-0 valid ignored
        i_req_valid = 2'b01; i_req_addr[0] = 32'h0300_0000;
        #1 chk("to_ready", o_req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b1, 1'b1);
        tick;
        i_req_valid = 2'b00;
        #1 chk("to_rden", o_rule_rden, 4'b1000);
        i_rule_rdata[0] = 32'hBAD0_0000;
        for (int i = 0; i < 15; i++) begin
            tick;
            i_rule_rdata_valid = (i == 5) ? 4'b0001 : 4'b0000;
            #1 chk("to_wait", o_resp_valid, 0);
            chk("to_busy", o_busy, 1);
        end
        i_rule_rdata_valid = '0;
        tick;
        #1 check_resp("to_resp");
        tick;

        // same read, data arrives on the 15th WAIT_RD cycle
        i_req_valid = 2'b01;
        #1 chk("late_ready", o_req_ready, 2'b01);
        push(1'b0, 32'h0BEE_F00D, 1'b0, 1'b1);
        tick;
        i_req_valid = 2'b00;
        i_rule_rdata[3] = 32'h0BEE_F00D;
        for (int i = 0; i < 15; i++) begin
            tick;
            i_rule_rdata_valid = (i == 14) ? 4'b1000 : 4'b0000;
            #1 chk("late_wait", o_resp_valid, 0);
        end
        tick;
        i_rule_rdata_valid = '0;
        #1 check_resp("late_resp");
        tick;

        // bad layer index: error response the cycle after accept, no strobe
        i_req_valid = 2'b10; i_req_addr[1] = 32'h0500_0000;
        #1 chk("bad_ready", o_req_ready, 2'b10);
        push(1'b1, 32'h0, 1'b1, 1'b0);
        tick;
        i_req_valid = 2'b00;
        #1 check_resp("bad_resp");
        chk("bad_strobes", {o_rule_wren, o_rule_rden}, 0);
        tick;
        #1 chk("bad_idle", o_busy, 0);

        // reset during WAIT_RD aborts the request silently
        i_req_valid = 2'b01; i_req_addr[0] = 32'h0300_0000;
        #1 chk("abort_ready", o_req_ready, 2'b01);
        tick;
        i_req_valid = 2'b00;
        tick; tick;
        i_rst = 1'b1;
        #1 chk("abort_busy", o_busy, 0);
        chk("abort_strobes", {o_rule_wren, o_rule_rden}, 0);
        chk("abort_resp", o_resp_valid, 0);
        chk("abort_addr", o_rule_addr, 0);
        tick; tick;
        i_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            #1 chk("abort_no_resp", o_resp_valid, 0);
        end

        // rr pointer back at 0: req0 wins the tie
        i_req_valid = 2'b11; i_req_wr = 2'b01;
        i_req_addr[0] = 32'h0000_0020; i_req_wdata[0] = 32'h5555_AAAA;
        i_req_addr[1] = 32'h0100_0000;
        #1 chk("post_rst_rr", o_req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        i_req_valid = 2'b00;
        #1 chk("post_rst_wren", o_rule_wren, 4'b0001);
        chk("post_rst_wdata", o_rule_wdata, 32'h5555_AAAA);
        tick;
        #1 check_resp("post_rst_resp");
        tick;

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deparser_rule_conf_arbiter.md
Name: deparser_rule_conf_arbiter

Overview:
- Shares one rule-configuration path between two requesters: requester 0 is host/DMA, requester 1 is the on-chip CPU.
- Serves LAYER_NUM deparser layer instances, each exposing the rule_wren/rule_rden/addr/wdata/rdata_valid/rdata config port.
- Arbitrates round-robin, decodes the target layer from the address, and issues a single-cycle strobe to that layer.
- Collects read data with a timeout, then returns a response to the requester that won arbitration.

Parameters:
- LAYER_NUM, 4: number of deparser layers served (max 256).
- LAYER_SEL_LSB, 24: addr[LAYER_SEL_LSB+:8] selects the layer; the full 32-bit address is passed through to the layer.
- TIMEOUT, 15: maximum cycles spent waiting for read data before an error response.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req_valid  in  2  request valid per requester; held until accepted.
- i_req_wr  in  2  1=write, 0=read, per requester.
- i_req_addr  in  2x32  request address per requester.
- i_req_wdata  in  2x32  write data per requester.
- o_req_ready  out  2  accept pulse; one-hot or zero.
- o_resp_valid  out  2  one-cycle completion pulse to the owning requester.
- o_resp_rdata  out  32  read data; shared, qualified by o_resp_valid.
- o_resp_err  out  1  1 = bad layer index or timeout; qualified by o_resp_valid.
- o_rule_wren  out  LAYER_NUM  per-layer write strobe.
- o_rule_rden  out  LAYER_NUM  per-layer read strobe.
- o_rule_addr  out  32  registered address, shared by all layers.
- o_rule_wdata  out  32  registered write data, shared by all layers.
- i_rule_rdata_valid  in  LAYER_NUM  per-layer read-data valid.
- i_rule_rdata  in  LAYERx32  per-layer read data.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, i_rst=1): all outputs 0, FSM=IDLE, rr pointer=0, timeout counter=0.
- Reset asserted mid-transaction aborts it: strobes drop immediately and no response is ever emitted for the aborted request.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - Grant = requester with valid; if both are valid, grant the rr pointer.
  - o_req_ready[grant] is asserted combinationally in the same cycle.
  - Capture wr, addr, wdata and owner; set the rr pointer to the other requester.
  - Compute sel = addr[LAYER_SEL_LSB+:8]. If sel >= LAYER_NUM, set a pending error and go to RESP (no strobe); otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive o_rule_wren[sel] or o_rule_rden[sel] = 1; o_rule_addr/o_rule_wdata hold the captured values.
  - Write: next state RESP with err=0.
  - Read with i_rule_rdata_valid[sel]=1 in this cycle: capture i_rule_rdata[sel] and go to RESP. Otherwise go to WAIT_RD and clear the counter.
- WAIT_RD:
  - Counter increments each cycle.
  - If i_rule_rdata_valid[sel]=1: capture data, go to RESP with err=0.
  - Else if counter == TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - Valid arriving in the same cycle as the timeout wins, i.e. a data response with err=0.
  - Valid from non-selected layers is ignored.
- RESP (1 cycle): o_resp_valid[owner]=1 with o_resp_rdata and o_resp_err; next state IDLE.
- Accepts are never back-to-back: minimum spacing is write 3 cycles (IDLE, ISSUE, RESP); a bad-address request takes 2 cycles.
- Requests arriving while not IDLE see o_req_ready=0 and must stay held.
- Requester valid dropping before accept is legal; nothing is recorded.
- Strobes are one-hot and asserted only in ISSUE, never simultaneously.
- o_rule_addr/o_rule_wdata keep their last value outside ISSUE.
- o_resp_rdata holds its last value outside RESP.

Test Plan:
- Req0 write addr=0x0100_0010, wdata=0xA5A5_0001 -> o_req_ready[0] same cycle; next cycle o_rule_wren=4'b0010 for one cycle with addr/wdata matching; next cycle o_resp_valid[0]=1, err=0.
- Req0 and req1 read valid together from reset -> req0 is granted first, req1 granted at the next IDLE; requests alternate while both stay valid; o_rule_rden is one-hot each time.
- Read layer 2 with rdata_valid returned in the ISSUE cycle with data 0x1234_5678 -> RESP next cycle with rdata=0x1234_5678, err=0; total 3 cycles from accept.
- Read layer 3 with no valid, TIMEOUT=15 -> o_resp_err=1, rdata=0 after exactly 15 WAIT_RD cycles; valid on the 15th cycle instead -> err=0 with the data.
- Address 0x0500_0000 with LAYER_NUM=4 -> no strobes; o_resp_valid with err=1 on the cycle after accept.
- i_rst pulsed during WAIT_RD -> all outputs 0 immediately; no o_resp_valid afterwards; a new request after reset completes normally with the rr pointer back at 0.
